// File: rtl/ex_div_pkg.sv
// Shared constants and types for the execute-stage divider.
// State codes, handshake levels and iteration count used by ex_div.
package ex_div_pkg;

  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [5:0] DIV_ITERATIONS = 6'd32;

endpackage

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit restoring divider for the execute stage.
// One subtract-and-shift per cycle; result is {remainder, quotient}.
// Signed DIV support is built only when EX_DIV_SIGNED_EN is defined;
// otherwise every operation is unsigned and signed_div_i is ignored.
//
// Handshake: the execute stage holds start_i high (and stalls) until it
// sees ready_o. ready_o/result_o stay valid while start_i remains high and
// clear one edge after start_i drops. annul_i aborts a running operation.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [RESULT_W-1:0] result_o,
  output logic                ready_o,
  output div_state_e          state
);

  div_state_e          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [64:0]         work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [RESULT_W-1:0] result_d;
  logic                ready_d;

  logic [32:0]         diff;
  logic [DATA_W-1:0]   dividend_abs;
  logic [DATA_W-1:0]   divisor_abs;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

`ifdef EX_DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
`endif

  assign state = state_q;

  // Next-state, datapath step and output values for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    result_d  = result_o;
    ready_d   = ready_o;

    // Partial remainder never exceeds 32 bits, so work[63:32] is the full compare value.
    diff         = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    dividend_abs = opdata1_i;
    divisor_abs  = opdata2_i;
    quot_fix     = work_q[31:0];
    rem_fix      = work_q[64:33];

`ifdef EX_DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (signed_div_i && opdata1_i[DATA_W-1]) dividend_abs = -opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1]) divisor_abs  = -opdata2_i;
    if (neg_quot_q) quot_fix = -work_q[31:0];
    if (neg_rem_q)  rem_fix  = -work_q[64:33];
`endif

    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            divisor_d = divisor_abs;
            work_d    = {32'b0, dividend_abs, 1'b0};
`ifdef EX_DIV_SIGNED_EN
            neg_quot_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d  = signed_div_i && opdata1_i[DATA_W-1];
`endif
          end
        end
      end
      DIV_BY_ZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          ready_d = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else if (cnt_q != DIV_ITERATIONS) begin
          if (diff[32]) work_d = {work_q[63:0], 1'b0};
          else          work_d = {diff[31:0], work_q[31:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          ready_d  = DIV_RESULT_READY;
          result_d = {rem_fix, quot_fix};
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // Register state, datapath and outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

`ifdef EX_DIV_SIGNED_EN
  // Sign-correction flags captured at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`endif

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div (unsigned build, or signed build when
// EX_DIV_SIGNED_EN is defined; expectations follow the same macro).
module tb_ex_div;
  import ex_div_pkg::*;

`ifdef EX_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] result;
  logic        ready;
  div_state_e  state;

  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .state        (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: truncating division on magnitudes, signs applied afterwards.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] ua, ub, q, r;
    logic        s;
    s = sgn & SIGNED_EN;
    if (b == 32'd0) return 64'd0;
    ua = (s && a[31]) ? (32'd0 - a) : a;
    ub = (s && b[31]) ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  // Driver + scoreboard: push expectation, hold start until ready, check latency,
  // result, hold behaviour and release.
  task automatic run_req(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp_val, input int lat_want);
    int          lat;
    logic        got;
    logic [63:0] want;
    exp_q.push_back(exp_val);
    signed_div = sgn; opdata1 = a; opdata2 = b; annul = 1'b0; start = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
      end
      got = (ready === 1'b1);
    end
    want = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL %s ready: never rose in %0d cycles", name, lat);
    end
    total++;
    if (lat !== lat_want) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, lat_want);
    end
    total++;
    if (result !== want) begin
      bad++; $display("FAIL %s result: got %h want %h", name, result, want);
    end
    repeat (3) @(negedge clk);
    total++;
    if (ready !== 1'b1 || result !== want) begin
      bad++; $display("FAIL %s hold: ready %b result %h want 1 %h", name, ready, result, want);
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || result !== 64'd0 || state !== DIV_FREE) begin
      bad++; $display("FAIL %s release: ready %b result %h state %s want 0 0 DIV_FREE",
                      name, ready, result, state.name());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ready !== 1'b0 || result !== 64'd0 || state !== DIV_FREE) begin
      bad++; $display("FAIL reset: ready %b result %h state %s want 0 0 DIV_FREE",
                      ready, result, state.name());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    run_req("u_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 34);
    run_req("u_5_10", 32'd5, 32'd10, 1'b0, {32'd5, 32'd0}, 34);
    run_req("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 34);
    run_req("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'd1}, 34);
  endtask

  task automatic test_signed();
    run_req("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
            SIGNED_EN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'h1, 32'h7FFF_FFFC}, 34);
    run_req("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
            SIGNED_EN ? {32'h1, 32'hFFFF_FFFD} : {32'h7, 32'h0}, 34);
    run_req("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
            SIGNED_EN ? {32'h0, 32'h8000_0000} : {32'h8000_0000, 32'h0}, 34);
  endtask

  task automatic test_div_by_zero();
    run_req("zero_5_0", 32'd5, 32'd0, 1'b0, 64'd0, 2);
    // annul while in the divide-by-zero state
    opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
    @(negedge clk);
    total++;
    if (state !== DIV_BY_ZERO) begin
      bad++; $display("FAIL zero_state: got %s want DIV_BY_ZERO", state.name());
    end
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    total++;
    if (state !== DIV_FREE || ready !== 1'b0 || result !== 64'd0) begin
      bad++; $display("FAIL zero_annul: state %s ready %b result %h want DIV_FREE 0 0",
                      state.name(), ready, result);
    end
    annul = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_annul();
    logic seen;
    // start together with annul is ignored
    opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (state !== DIV_FREE || ready !== 1'b0) begin
      bad++; $display("FAIL start_annul: state %s ready %b want DIV_FREE 0", state.name(), ready);
    end
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    // annul at iteration 10
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (state !== DIV_ON) begin
      bad++; $display("FAIL annul_running: got %s want DIV_ON", state.name());
    end
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    total++;
    if (state !== DIV_FREE || ready !== 1'b0 || result !== 64'd0) begin
      bad++; $display("FAIL annul_abort: state %s ready %b result %h want DIV_FREE 0 0",
                      state.name(), ready, result);
    end
    annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL annul_quiet: ready rose %b want 0", seen);
    end
    run_req("annul_follow_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34);
  endtask

  task automatic test_reset_mid_run();
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || result !== 64'd0 || state !== DIV_FREE) begin
      bad++; $display("FAIL reset_mid: ready %b result %h state %s want 0 0 DIV_FREE",
                      ready, result, state.name());
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      s = 1'($urandom_range(0, 1));
      run_req($sformatf("rand_%0d", i), a, b, s, model(a, b, s), (b == 32'd0) ? 2 : 34);
    end
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
